rv_pipe_chain: RTL and testbench

- Parametrised successor to the plain enabled data register: a chain of DEPTH register slices with a valid/ready handshake and a synchronous flush.
- Each slice holds one main entry and one skid entry, so ready is registered and the chain sustains one transfer per cycle.
- Used to model or insert fixed latency between CPU fetch, instruction memory and decode, where the downstream can stall and a branch can flush in-flight words.

---
 rtl/rv_pipe_chain_pkg.sv | 10 +
 rtl/rv_pipe_slice.sv | 55 +++++
 rtl/rv_pipe_chain.sv | 70 +++++++
 tb/tb_rv_pipe_chain.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_chain_pkg.sv
// Shared parameters and helpers for the rv_pipe_chain register-slice pipeline.
package rv_pipe_chain_pkg;

  localparam int DEFAULT_WIDTH_DATA = 32;

  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/rv_pipe_slice.sv
// One valid/ready register slice with main + skid entry; latency 1 cycle.
// in_ready is registered (!skid_valid), so no comb path runs from out_ready to in_ready.
module rv_pipe_slice
  import rv_pipe_chain_pkg::*;
#(
  parameter int                    WIDTH_DATA  = DEFAULT_WIDTH_DATA,
  parameter logic [WIDTH_DATA-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [WIDTH_DATA-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH_DATA-1:0] out_data,
  input  logic                  out_ready
);

  logic                  main_valid;
  logic                  skid_valid;
  logic [WIDTH_DATA-1:0] main_data;
  logic [WIDTH_DATA-1:0] skid_data;
  logic                  push;
  logic                  pop;

  assign push = in_valid && !skid_valid;
  assign pop  = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= RESET_VALUE;
      skid_data  <= RESET_VALUE;
    end else if (pop && skid_valid) begin
      // skid full means no push can happen this cycle
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end else if (push && (!main_valid || pop)) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/rv_pipe_chain.sv
// DEPTH-slice valid/ready pipeline with flush; latency DEPTH cycles, capacity 2*DEPTH.
// Full backpressure via registered ready per slice; RV_PIPE_CHAIN_OCCUPANCY_EN adds an occupancy count.
module rv_pipe_chain
  import rv_pipe_chain_pkg::*;
#(
  parameter int                    WIDTH_DATA  = DEFAULT_WIDTH_DATA,
  parameter int                    DEPTH       = 2,
  parameter logic [WIDTH_DATA-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [WIDTH_DATA-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH_DATA-1:0] out_data,
`ifdef RV_PIPE_CHAIN_OCCUPANCY_EN
  output logic [occ_width(DEPTH)-1:0] occupancy,
`endif
  input  logic                  out_ready
);

  logic [DEPTH:0]        link_valid;
  logic [DEPTH:0]        link_ready;
  logic [WIDTH_DATA-1:0] link_data [DEPTH+1];

  assign link_valid[0]     = in_valid;
  assign link_data[0]      = in_data;
  assign in_ready          = link_ready[0];
  assign out_valid         = link_valid[DEPTH];
  assign out_data          = link_data[DEPTH];
  assign link_ready[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    rv_pipe_slice #(
      .WIDTH_DATA  (WIDTH_DATA),
      .RESET_VALUE (RESET_VALUE)
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (link_valid[i]),
      .in_data   (link_data[i]),
      .in_ready  (link_ready[i]),
      .out_valid (link_valid[i+1]),
      .out_data  (link_data[i+1]),
      .out_ready (link_ready[i+1])
    );
  end

`ifdef RV_PIPE_CHAIN_OCCUPANCY_EN
  localparam int OW = occ_width(DEPTH);

  logic push;
  logic pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OW'(push) - OW'(pop);
    end
  end
`endif

endmodule

// File: tb/tb_rv_pipe_chain.sv
// Scoreboard bench for rv_pipe_chain (DEPTH=3): reset, latency, fill, random stream, flush, rst+flush.
module tb_rv_pipe_chain;
  import rv_pipe_chain_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
`ifdef RV_PIPE_CHAIN_OCCUPANCY_EN
  logic [occ_width(DEPTH)-1:0] occupancy;
`endif

  rv_pipe_chain #(.WIDTH_DATA(W), .DEPTH(DEPTH), .RESET_VALUE('0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef RV_PIPE_CHAIN_OCCUPANCY_EN
    .occupancy (occupancy),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] sb_q[$];
  logic         hold_vld = 1'b0;
  logic [W-1:0] hold_dat;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, W'(sb_q.size()), '0);
  endtask

  // Monitor: transfers are decided at the next posedge; inputs and registered outputs are stable here
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      hold_vld = 1'b0;
    end else begin
`ifdef RV_PIPE_CHAIN_OCCUPANCY_EN
      chk("occupancy", W'(occupancy), W'(sb_q.size()));
`endif
      if (hold_vld) begin
        chk("hold_valid", W'(out_valid), 1);
        chk("hold_data", out_data, hold_dat);
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (sb_q.size() == 0) chk("sb_underflow_size", W'(sb_q.size()), 1);
        else chk("out_data", out_data, sb_q.pop_front());
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_data);
      hold_vld = out_valid && !out_ready && !flush;
      hold_dat = out_data;
    end
  end

  initial begin
    int acc;
    int sent;
    int cyc;
    logic fire;

    // reset with a transfer offered that must be dropped
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", W'(in_ready), 1);
    repeat (4) tick();

    // latency: three back-to-back words
    in_valid = 1'b1; in_data = 32'h11;
    tick(); in_data = 32'h22;
    @(negedge clk); chk("lat_valid_e1", W'(out_valid), 0);
    tick(); in_data = 32'h33;
    @(negedge clk); chk("lat_valid_e2", W'(out_valid), 0);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("lat_valid_e3", W'(out_valid), 1); chk("lat_data0", out_data, 32'h11);
    tick();
    @(negedge clk); chk("lat_data1", out_data, 32'h22);
    tick();
    @(negedge clk); chk("lat_data2", out_data, 32'h33);
    drain("lat_drain");

    // backpressure fill
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h100; acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) acc++;
      tick();
      in_data = in_data + 1;
    end
    @(negedge clk);
    chk("fill_accepted", W'(acc), W'(2 * DEPTH));
    chk("fill_in_ready", W'(in_ready), 0);
    chk("fill_out_data", out_data, 32'h100);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    drain("fill_drain");

    // random valid stream, out_ready toggling every cycle
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 5000) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      tick();
      if (fire) sent++;
      out_ready = ~out_ready;
      if (!in_valid || fire) begin
        in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
        in_data  = $urandom;
      end
      cyc++;
    end
    chk("stream_sent", W'(sent), 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    drain("stream_drain");

    // flush with three words in flight and a simultaneous push
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA1;
    tick(); in_data = 32'hA2;
    tick(); in_data = 32'hA3;
    tick();
    flush = 1'b1; in_data = 32'hAA; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", W'(out_valid), 0);
    chk("flush_in_ready", W'(in_ready), 1);
    chk("flush_sb_empty", W'(sb_q.size()), 0);
    repeat (2 * DEPTH) tick();

    // rst and flush together while full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h200;
    repeat (2 * DEPTH + 2) begin
      tick();
      in_data = in_data + 1;
    end
    in_valid = 1'b0;
    @(negedge clk); chk("full_in_ready", W'(in_ready), 0);
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("rf_out_valid", W'(out_valid), 0);
    chk("rf_out_data", out_data, 0);
    chk("rf_in_ready", W'(in_ready), 1);
    tick();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("rf_lat_e1", W'(out_valid), 0);
    tick();
    @(negedge clk); chk("rf_lat_e2", W'(out_valid), 0);
    tick();
    @(negedge clk); chk("rf_lat_e3", W'(out_valid), 1); chk("rf_data", out_data, 32'h55);
    drain("rf_drain");
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
